// File: rtl/imm_dec_if.sv
// imm_dec_if: fetch/execute handshake and imm_gen drive bundle for imm_dec_ctrl.
interface imm_dec_if #(parameter int CNT_W = 16);
    logic [31:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       sel;
    logic [31:0]      imm_instr;
    logic             dec_valid;
    logic [2:0]       dec_sel;
    logic             dec_illegal;
    logic             out_ready;
    logic             flush;
    logic [CNT_W-1:0] issued_cnt;
    modport master (
        output instr, instr_valid, out_ready, flush,
        input  instr_ready, sel, imm_instr, dec_valid, dec_sel, dec_illegal, issued_cnt
    );
    modport slave (
        input  instr, instr_valid, out_ready, flush,
        output instr_ready, sel, imm_instr, dec_valid, dec_sel, dec_illegal, issued_cnt
    );
endinterface

// File: rtl/imm_dec_ctrl.sv
// imm_dec_ctrl: buffers fetched instructions, decodes imm_gen select and presents
// each instruction downstream aligned with imm_gen's registered immediate.
module imm_dec_ctrl #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input logic      clk,
    input logic      rst,
    imm_dec_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    function automatic logic [3:0] decode(input logic [6:0] op);
        case (op)
            7'b0010011: decode = 4'h1;
            7'b0000011: decode = 4'h2;
            7'b0100011: decode = 4'h3;
            7'b1100011: decode = 4'h4;
            7'b1100111: decode = 4'h5;
            7'b1101111: decode = 4'h6;
            7'b0110111, 7'b0010111: decode = 4'h7;
            7'b0110011, 7'b1110011, 7'b0001111: decode = 4'h0;
            default: decode = 4'h8;
        endcase
    endfunction

    logic [31:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]    wp, rp;
    logic [31:0]      head, cur_instr;
    logic [3:0]       head_dec;
    logic [2:0]       cur_sel;
    logic             cur_ill, dec_valid, empty, full, push, load;
    logic [CNT_W-1:0] cnt;

    assign empty    = wp == rp;
    assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign push     = bus.instr_valid && !full && !bus.flush;
    assign load     = !empty && (!dec_valid || bus.out_ready) && !bus.flush;
    assign head     = mem[rp[AW-1:0]];
    assign head_dec = decode(head[6:0]);

    // imm_gen registers on the same edge we load, so feed it the head while loading
    assign bus.sel         = load ? head_dec[2:0] : cur_sel;
    assign bus.imm_instr   = load ? head : cur_instr;
    assign bus.instr_ready = !full;
    assign bus.dec_valid   = dec_valid;
    assign bus.dec_sel     = cur_sel;
    assign bus.dec_illegal = cur_ill;
    assign bus.issued_cnt  = cnt;

    always_ff @(posedge clk)
        if (push) mem[wp[AW-1:0]] <= bus.instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            rp        <= '0;
            dec_valid <= 1'b0;
            cur_instr <= '0;
            cur_sel   <= '0;
            cur_ill   <= 1'b0;
            cnt       <= '0;
        end else begin
            wp        <= wp + PW'(push);
            rp        <= bus.flush ? wp : rp + PW'(load);
            dec_valid <= !bus.flush && (load || (dec_valid && !bus.out_ready));
            cnt       <= cnt + CNT_W'(dec_valid && bus.out_ready);
            if (load) begin
                cur_instr <= head;
                cur_sel   <= head_dec[2:0];
                cur_ill   <= head_dec[3];
            end
        end
    end
endmodule

// File: tb/tb_imm_dec_ctrl.sv
// tb_imm_dec_ctrl: table-driven and sequence checks of imm_dec_ctrl with a
// registered imm_gen reference model on its sel/imm_instr outputs.
module tb_imm_dec_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] imm;
    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    imm_dec_if #(.CNT_W(16)) bus ();
    imm_dec_ctrl #(.FIFO_DEPTH(2), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic logic [31:0] immf(input logic [2:0] s, input logic [31:0] i);
        case (s)
            3'd1, 3'd2, 3'd5: immf = {{20{i[31]}}, i[31:20]};
            3'd3: immf = {{20{i[31]}}, i[31:25], i[11:7]};
            3'd4: immf = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd6: immf = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd7: immf = {i[31:12], 12'h000};
            default: immf = 32'h0;
        endcase
    endfunction

    // imm_gen stand-in: synchronous reset, one register stage
    always_ff @(posedge clk) imm <= rst ? 32'h0 : immf(bus.sel, bus.imm_instr);

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  sel;
        logic        ill;
        logic [31:0] imm;
    } vec_t;
    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        v[0]  = '{32'hFFF00093, 3'd1, 1'b0, 32'hFFFFFFFF};
        v[1]  = '{32'h00812103, 3'd2, 1'b0, 32'h00000008};
        v[2]  = '{32'h00112423, 3'd3, 1'b0, 32'h00000008};
        v[3]  = '{32'hFE000EE3, 3'd4, 1'b0, 32'hFFFFFFFC};
        v[4]  = '{32'h00008067, 3'd5, 1'b0, 32'h00000000};
        v[5]  = '{32'h0000006F, 3'd6, 1'b0, 32'h00000000};
        v[6]  = '{32'h12345037, 3'd7, 1'b0, 32'h12345000};
        v[7]  = '{32'h80000517, 3'd7, 1'b0, 32'h80000000};
        v[8]  = '{32'h00A00033, 3'd0, 1'b0, 32'h00000000};
        v[9]  = '{32'h00000073, 3'd0, 1'b0, 32'h00000000};
        v[10] = '{32'h0000007F, 3'd0, 1'b1, 32'h00000000};
        bus.instr = '0;
        bus.instr_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush = 1'b0;
        exp_cnt = '0;
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        chk("rst dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst dec_sel", 32'(bus.dec_sel), 32'd0);
        chk("rst dec_illegal", 32'(bus.dec_illegal), 32'd0);
        chk("rst cnt", 32'(bus.issued_cnt), 32'd0);
        chk("rst sel", 32'(bus.sel), 32'd0);
        chk("rst imm_instr", bus.imm_instr, 32'd0);
        chk("rst instr_ready", 32'(bus.instr_ready), 32'd1);

        // single instruction per vector: push, present one edge later, drain
        for (int k = 0; k < 11; k++) begin
            bus.instr = v[k].instr;
            bus.instr_valid = 1'b1;
            bus.out_ready = 1'b1;
            cyc();
            bus.instr_valid = 1'b0;
            cyc();
            chk($sformatf("vec%0d dec_valid", k), 32'(bus.dec_valid), 32'd1);
            chk($sformatf("vec%0d dec_sel", k), 32'(bus.dec_sel), 32'(v[k].sel));
            chk($sformatf("vec%0d sel", k), 32'(bus.sel), 32'(v[k].sel));
            chk($sformatf("vec%0d illegal", k), 32'(bus.dec_illegal), 32'(v[k].ill));
            chk($sformatf("vec%0d imm", k), imm, v[k].imm);
            cyc();
            exp_cnt++;
            chk($sformatf("vec%0d drained", k), 32'(bus.dec_valid), 32'd0);
            chk($sformatf("vec%0d cnt", k), 32'(bus.issued_cnt), 32'(exp_cnt));
        end

        // back-to-back stream: one presentation per cycle
        for (int k = 0; k < 5; k++) begin
            bus.instr = v[k < 4 ? (k == 3 ? 5 : k + 1) : 0].instr;
            bus.instr_valid = k < 4;
            cyc();
            if (k >= 1) begin
                chk($sformatf("stream%0d valid", k), 32'(bus.dec_valid), 32'd1);
                chk($sformatf("stream%0d sel", k), 32'(bus.dec_sel), 32'(k == 4 ? 6 : k + 1));
            end
        end
        bus.instr_valid = 1'b0;
        cyc();
        exp_cnt += 4;
        chk("stream drained", 32'(bus.dec_valid), 32'd0);
        chk("stream cnt", 32'(bus.issued_cnt), 32'(exp_cnt));

        // backpressure: fill FIFO behind a held presentation, then drain in order
        bus.out_ready = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr = 32'h00812103;
        cyc();
        bus.instr = 32'h00112423;
        cyc();
        bus.instr = 32'h12345037;
        cyc();
        chk("bp full", 32'(bus.instr_ready), 32'd0);
        chk("bp valid", 32'(bus.dec_valid), 32'd1);
        chk("bp sel", 32'(bus.dec_sel), 32'd2);
        chk("bp imm", imm, 32'h8);
        bus.instr = 32'h0000006F;
        cyc();
        chk("bp blocked ready", 32'(bus.instr_ready), 32'd0);
        chk("bp hold sel", 32'(bus.dec_sel), 32'd2);
        chk("bp hold imm", imm, 32'h8);
        chk("bp hold cnt", 32'(bus.issued_cnt), 32'(exp_cnt));
        bus.instr_valid = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        chk("bp drain1 sel", 32'(bus.dec_sel), 32'd3);
        chk("bp drain1 imm", imm, 32'h8);
        cyc();
        chk("bp drain2 sel", 32'(bus.dec_sel), 32'd7);
        chk("bp drain2 imm", imm, 32'h12345000);
        cyc();
        exp_cnt += 3;
        chk("bp no dup", 32'(bus.dec_valid), 32'd0);
        chk("bp ready", 32'(bus.instr_ready), 32'd1);
        chk("bp cnt", 32'(bus.issued_cnt), 32'(exp_cnt));

        // asynchronous reset in the middle of a cycle with work in flight
        bus.out_ready = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr = 32'h00812103;
        cyc();
        cyc();
        #2 rst = 1'b1;
        #1;
        chk("arst dec_valid", 32'(bus.dec_valid), 32'd0);
        chk("arst cnt", 32'(bus.issued_cnt), 32'd0);
        chk("arst dec_sel", 32'(bus.dec_sel), 32'd0);
        chk("arst sel", 32'(bus.sel), 32'd0);
        chk("arst imm_instr", bus.imm_instr, 32'd0);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst instr_ready", 32'(bus.instr_ready), 32'd1);
        @(negedge clk);
        cyc();
        chk("arst nothing left", 32'(bus.dec_valid), 32'd0);

        // run the counter to 0xFFFF, then flush with FIFO full and a push pending
        bus.out_ready = 1'b1;
        bus.instr_valid = 1'b1;
        bus.instr = 32'hFFF00093;
        for (int n = 0; n < 70000; n++) begin
            if (bus.issued_cnt == 16'hFFFF) break;
            cyc();
        end
        chk("wrap reached", 32'(bus.issued_cnt), 32'h0000FFFF);
        bus.out_ready = 1'b0;
        cyc();
        cyc();
        chk("pre-flush full", 32'(bus.instr_ready), 32'd0);
        chk("pre-flush valid", 32'(bus.dec_valid), 32'd1);
        bus.instr = 32'h0000006F;
        bus.flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("flush imm_instr hold", bus.imm_instr, 32'hFFF00093);
        chk("flush sel hold", 32'(bus.sel), 32'd1);
        @(negedge clk);
        cyc();
        chk("flush cnt wrap", 32'(bus.issued_cnt), 32'd0);
        chk("flush valid", 32'(bus.dec_valid), 32'd0);
        chk("flush empty", 32'(bus.instr_ready), 32'd1);
        bus.flush = 1'b0;
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("flush dropped%0d", k), 32'(bus.dec_valid), 32'd0);
        end
        chk("flush cnt idle", 32'(bus.issued_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
